aes_axi_block_if: RTL and testbench
===================================

AES_AXI_BLOCK_IF -- requirements
Module: aes_axi_block_if

Interface
REQ-001 SHALL have parameter WORD_W, default 32, host word width; legal values 32, 64, 128.
REQ-002 SHALL have parameter IN_DEPTH, default 2, input block FIFO depth in 128-bit blocks; power of two, 1..8.
REQ-003 SHALL have parameter AUTO_DEFAULT, default 0, reset value of control bit AUTO.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_valid  input  1  host write valid.
REQ-007 SHALL have port s_addr  input  1  0 = control register, 1 = data word.
REQ-008 SHALL have port s_data  input  WORD_W  host write data.
REQ-009 SHALL have port s_ready  output  1  write accepted when s_valid & s_ready.
REQ-010 SHALL have port core_start  output  1  one-cycle launch pulse to AES core.
REQ-011 SHALL have port core_din  output  128  plaintext block to core, valid while core_start=1.
REQ-012 SHALL have port core_done  input  1  one-cycle completion pulse from core.
REQ-013 SHALL have port core_dout  input  128  ciphertext, valid while core_done=1.
REQ-014 SHALL have port m_valid  output  1  output word valid.
REQ-015 SHALL have port m_ready  input  1  host ready for output word.
REQ-016 SHALL have port m_data  output  WORD_W  output word.
REQ-017 SHALL have port m_last  output  1  marks final word of a block.
REQ-018 SHALL have port busy  output  1  FSM not IDLE or FIFO non-empty.
REQ-019 SHALL have port err  output  1  sticky protocol error.

Function
REQ-020 Control write (s_addr=0) bits: [0] START (self-clearing), [1] AUTO, [2] CLEAR (self-clearing); other bits ignored.
REQ-021 Control writes SHALL always be accepted: s_ready = ~s_addr | ~(FIFO full & packer holds WPB-1 words), WPB = 128/WORD_W.
REQ-022 Packer: accepted data words fill block MSB-first; word k lands in bits [127-k*WORD_W -: WORD_W].
REQ-023 On the WPB-th word the block SHALL be pushed to the FIFO the same edge; packer count returns to 0.
REQ-024 START SHALL increment a dispatch credit counter saturating at IN_DEPTH; ignored when AUTO=1.
REQ-025 FSM states IDLE, WAIT, DRAIN.
REQ-026 IDLE -> WAIT when FIFO non-empty and (AUTO=1 or credit>0): core_start=1 for exactly that cycle, core_din = FIFO head, FIFO popped, credit decremented if AUTO=0.
REQ-027 WAIT -> DRAIN on core_done: core_dout captured into output register, word index 0.
REQ-028 DRAIN: m_valid=1, m_data = output word index (MSB-first); m_data stable while m_valid & ~m_ready; index advances on m_valid & m_ready.
REQ-029 m_last=1 while index = WPB-1; handshake on last word -> IDLE; a new dispatch MAY launch on the next cycle.
REQ-030 Dispatch latency: core_start no earlier than 1 cycle after the condition in REQ-026 becomes true.
REQ-031 CLEAR SHALL empty packer, FIFO and credits in one cycle; in-flight WAIT/DRAIN completes unaffected; err cleared.
REQ-032 START and CLEAR in the same write: CLEAR wins, credit = 0.
REQ-033 Data push and FIFO pop in the same cycle on a full FIFO SHALL both succeed; occupancy unchanged.
REQ-034 core_done outside WAIT SHALL set err and be otherwise ignored.
REQ-035 FIFO pointers SHALL wrap modulo IN_DEPTH with a separate occupancy count distinguishing full/empty.

Reset
REQ-036 resetn low SHALL asynchronously force: FSM IDLE, FIFO/packer/credits empty, AUTO=AUTO_DEFAULT, core_start=0, m_valid=0, m_last=0, m_data=0, busy=0, err=0, s_ready=1.
REQ-037 Reset mid-operation SHALL abandon any block; a later core_done while IDLE sets err.

Verification (WORD_W=32, IN_DEPTH=2, AUTO_DEFAULT=0)
REQ-038 Reset: assert resetn=0 mid-cycle -> all outputs at REQ-036 values before next clk edge.
REQ-039 Manual: data words 0x01000000, 0x02000000, 0x03000000, 0x04000000, then control 0x1 -> single core_start with core_din=0x01000000020000000300000004000000; no core_start before the control write.
REQ-040 Output: core model returns 0x633aadc43c56b3d6ea93bcfe994d587a -> m_data 0x633aadc4, 0x3c56b3d6, 0xea93bcfe, 0x994d587a, m_last on fourth only; m_ready low 3 cycles on word 2 -> m_data held.
REQ-041 Backpressure: 12 data words, no START -> s_ready=0 while 12th word presented; control write 0x1 accepted in same state; one block dispatched, 12th word then accepted.
REQ-042 Auto: control 0x2 then 8 data words -> two core_start pulses, second issued after first block's m_last handshake; no START writes needed.
REQ-043 Clear/err: 3 data words then control 0x5 -> no dispatch, packer empty; core_done while IDLE -> err=1 until next CLEAR.

Source files
------------

// File: rtl/aes_axi_block_if.sv
// aes_axi_block_if: host-side block interface for an AES core.
// The host writes data words that are packed MSB-first into 128-bit
// blocks and queued in a small FIFO. Blocks are launched on the core
// either by dispatch credits (START writes) or automatically (AUTO).
// The core result is then streamed back to the host one word at a time.
//
// Handshakes: a host write transfers on a rising edge where
// s_valid & s_ready; an output word transfers on a rising edge where
// m_valid & m_ready, and m_data/m_last stay stable while m_valid & ~m_ready.
module aes_axi_block_if #(
    parameter int WORD_W       = 32,
    parameter int IN_DEPTH     = 2,
    parameter bit AUTO_DEFAULT = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_valid,
    input  logic              s_addr,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              core_start,
    output logic [127:0]      core_din,
    input  logic              core_done,
    input  logic [127:0]      core_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              err
);

    localparam int WPB   = 128 / WORD_W;
    localparam int CNT_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int PTR_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int OCC_W = $clog2(IN_DEPTH + 1);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPB - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(IN_DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(IN_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic             r_auto;
    logic [OCC_W-1:0] r_credit;
    logic             r_err;

    logic [CNT_W-1:0] r_pack_cnt;
    logic [127:0]     r_pack;

    logic [127:0]     r_fifo [IN_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    logic             r_core_start;
    logic [127:0]     r_core_din;
    logic [127:0]     r_out;
    logic [CNT_W-1:0] r_out_idx;

    logic             w_full;
    logic             w_empty;
    logic             w_pack_last;
    logic             w_ctrl_wr;
    logic             w_data_wr;
    logic             w_clear;
    logic             w_start;
    logic             w_push;
    logic             w_dispatch;
    logic             w_credit_inc;
    logic             w_credit_dec;
    logic             w_done_err;
    logic [127:0]     w_block;

    assign w_full      = (r_occ == FULL_OCC);
    assign w_empty     = (r_occ == '0);
    assign w_pack_last = (r_pack_cnt == LAST_WORD);

    // Control writes are never stalled; data stalls only when the word
    // would complete a block that has nowhere to go.
    assign s_ready     = ~s_addr | ~(w_full & w_pack_last);

    assign w_ctrl_wr   = s_valid & ~s_addr;
    assign w_data_wr   = s_valid & s_addr & s_ready;
    assign w_clear     = w_ctrl_wr & s_data[2];
    // START is meaningless in AUTO mode; CLEAR overrides it below.
    assign w_start     = w_ctrl_wr & s_data[0] & ~r_auto;
    assign w_push      = w_data_wr & w_pack_last;
    assign w_dispatch  = (r_state == ST_IDLE) & ~w_empty & (r_auto | (r_credit != '0));
    assign w_credit_inc = w_start & (r_credit != FULL_OCC);
    assign w_credit_dec = w_dispatch & ~r_auto;
    assign w_done_err  = core_done & (r_state != ST_WAIT);

    // Current packer contents with the incoming word dropped into its slot.
    always_comb begin
        w_block = r_pack;
        w_block[127 - int'(r_pack_cnt) * WORD_W -: WORD_W] = s_data;
    end

    // Packer: word counter and partial block.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pack_cnt <= '0;
            r_pack     <= '0;
        end else if (w_clear) begin
            r_pack_cnt <= '0;
            r_pack     <= '0;
        end else if (w_data_wr) begin
            r_pack     <= w_block;
            r_pack_cnt <= w_pack_last ? '0 : r_pack_cnt + 1'b1;
        end
    end

    // FIFO storage; contents only matter where the occupancy says so.
    always_ff @(posedge clk) begin
        if (w_push && !w_clear) begin
            r_fifo[r_wr_ptr] <= w_block;
        end
    end

    // FIFO pointers wrap at IN_DEPTH; occupancy separates full from empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_dispatch) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_dispatch) begin
                r_occ <= r_occ + 1'b1;
            end else if (!w_push && w_dispatch) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    // AUTO bit follows every control write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_auto <= AUTO_DEFAULT;
        end else if (w_ctrl_wr) begin
            r_auto <= s_data[1];
        end
    end

    // Dispatch credits, saturating at the FIFO depth.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_credit <= '0;
        end else if (w_clear) begin
            r_credit <= '0;
        end else if (w_credit_inc && !w_credit_dec) begin
            r_credit <= r_credit + 1'b1;
        end else if (!w_credit_inc && w_credit_dec) begin
            r_credit <= r_credit - 1'b1;
        end
    end

    // Sticky error for a completion the core should not have sent.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (w_clear) begin
            r_err <= w_done_err;
        end else if (w_done_err) begin
            r_err <= 1'b1;
        end
    end

    // Main FSM: launch a block, wait for the core, stream the result out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_core_start <= 1'b0;
            r_core_din   <= '0;
            r_out        <= '0;
            r_out_idx    <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_dispatch) begin
                        r_core_start <= 1'b1;
                        r_core_din   <= r_fifo[r_rd_ptr];
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (core_done) begin
                        r_out     <= core_dout;
                        r_out_idx <= '0;
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (m_ready) begin
                        if (r_out_idx == LAST_WORD) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_out_idx <= r_out_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output word selection, MSB-first, zero outside DRAIN.
    always_comb begin
        m_data = '0;
        if (r_state == ST_DRAIN) begin
            m_data = r_out[127 - int'(r_out_idx) * WORD_W -: WORD_W];
        end
    end

    assign m_valid    = (r_state == ST_DRAIN);
    assign m_last     = (r_state == ST_DRAIN) && (r_out_idx == LAST_WORD);
    assign core_start = r_core_start;
    assign core_din   = r_core_din;
    assign busy       = (r_state != ST_IDLE) | ~w_empty;
    assign err        = r_err;

endmodule

// File: tb/tb_aes_axi_block_if.sv
// Directed bench for aes_axi_block_if with WORD_W=32, IN_DEPTH=2.
module tb_aes_axi_block_if;

  logic         clk;
  logic         resetn;
  logic         s_valid;
  logic         s_addr;
  logic [31:0]  s_data;
  logic         s_ready;
  logic         core_start;
  logic [127:0] core_din;
  logic         core_done;
  logic [127:0] core_dout;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  logic [127:0] last_din = '0;

  aes_axi_block_if #(
    .WORD_W(32),
    .IN_DEPTH(2),
    .AUTO_DEFAULT(1'b0)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .s_valid(s_valid),
    .s_addr(s_addr),
    .s_data(s_data),
    .s_ready(s_ready),
    .core_start(core_start),
    .core_din(core_din),
    .core_done(core_done),
    .core_dout(core_dout),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .busy(busy),
    .err(err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // launch monitor: counts core_start pulses away from the active edge
  always @(negedge clk) begin
    if (resetn && core_start) begin
      start_cnt = start_cnt + 1;
      last_din  = core_din;
    end
  end

  // host write; entered and left at posedge+1
  task automatic host_write(input logic a, input logic [31:0] d, input string name);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    s_valid = 1'b1;
    s_addr  = a;
    s_data  = d;
    while (!acc && n < 20) begin
      #1;
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    n_checks++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL %s write_accept: s_ready never high within 20 cycles (got %b, want 1)", name, acc);
    end
  endtask

  task automatic write_block(input logic [127:0] b, input string name);
    for (int k = 0; k < 4; k++) begin
      host_write(1'b1, b[127 - k*32 -: 32], name);
    end
  endtask

  task automatic wait_start(input int target, input string name);
    int n;
    n = 0;
    while (start_cnt < target && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (start_cnt !== target) begin
      n_fail++;
      $display("FAIL %s start_count: got %0d want %0d", name, start_cnt, target);
    end
  endtask

  task automatic core_reply(input logic [127:0] d);
    core_dout = d;
    core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
  endtask

  // stream one result block out, optionally stalling on one word
  task automatic drain_block(input logic [127:0] exp, input int stall_word, input string name);
    logic [31:0] ew;
    int n;
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int w = 0; w < 4; w++) begin
      ew = exp[127 - w*32 -: 32];
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== ew || m_last !== (w == 3)) begin
        n_fail++;
        $display("FAIL %s word%0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                 name, w, m_valid, m_data, m_last, ew, (w == 3));
      end
      if (w == stall_word) begin
        m_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          n_checks++;
          if (m_valid !== 1'b1 || m_data !== ew) begin
            n_fail++;
            $display("FAIL %s hold%0d: valid=%b data=%h want valid=1 data=%h", name, w, m_valid, m_data, ew);
          end
        end
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
    end
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_last: m_valid=%b want 0", name, m_valid);
    end
  endtask

  task automatic test_reset();
    s_addr = 1'b1;
    #1;
    n_checks++;
    if (core_start !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'h0 ||
        busy !== 1'b0 || err !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: start=%b mv=%b ml=%b md=%h busy=%b err=%b sr=%b want 0 0 0 0 0 0 1",
               core_start, m_valid, m_last, m_data, busy, err, s_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_manual_output();
    int base;
    base = start_cnt;
    write_block(128'h01000000_02000000_03000000_04000000, "manual");
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (start_cnt !== base || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL manual_no_early_start: starts=%0d busy=%b want %0d 1", start_cnt - base, busy, 0);
    end
    host_write(1'b0, 32'h1, "manual_ctrl");
    n_checks++;
    if (core_start !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_latency: core_start=%b on write edge, want 0", core_start);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (core_start !== 1'b1 || core_din !== 128'h01000000_02000000_03000000_04000000) begin
      n_fail++;
      $display("FAIL manual_launch: start=%b din=%h want 1 01000000020000000300000004000000", core_start, core_din);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (core_start !== 1'b0 || start_cnt !== base + 1) begin
      n_fail++;
      $display("FAIL manual_single_pulse: start=%b count=%0d want 0 %0d", core_start, start_cnt, base + 1);
    end
    core_reply(128'h633aadc4_3c56b3d6_ea93bcfe_994d587a);
    drain_block(128'h633aadc4_3c56b3d6_ea93bcfe_994d587a, 1, "output");
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL output_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = start_cnt;
    write_block(128'hA0000001_A0000002_A0000003_A0000004, "bp_a");
    write_block(128'hB0000001_B0000002_B0000003_B0000004, "bp_b");
    host_write(1'b1, 32'hC0000001, "bp_c");
    host_write(1'b1, 32'hC0000002, "bp_c");
    host_write(1'b1, 32'hC0000003, "bp_c");
    s_valid = 1'b1;
    s_addr  = 1'b1;
    s_data  = 32'hC0000004;
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall: s_ready=%b want 0", s_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (s_ready !== 1'b0 || start_cnt !== base) begin
      n_fail++;
      $display("FAIL bp_stall_hold: s_ready=%b starts=%0d want 0 %0d", s_ready, start_cnt - base, 0);
    end
    s_addr = 1'b0;
    s_data = 32'h1;
    #1;
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ctrl_ready: s_ready=%b want 1", s_ready);
    end
    s_valid = 1'b0;
    host_write(1'b0, 32'h1, "bp_ctrl");
    wait_start(base + 1, "bp_dispatch");
    n_checks++;
    if (last_din !== 128'hA0000001_A0000002_A0000003_A0000004) begin
      n_fail++;
      $display("FAIL bp_din: got %h want a0000001a0000002a0000003a0000004", last_din);
    end
    host_write(1'b1, 32'hC0000004, "bp_word12");
    core_reply(128'h0123456789abcdef_fedcba9876543210);
    drain_block(128'h0123456789abcdef_fedcba9876543210, -1, "bp_out");
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (start_cnt !== base + 1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_no_credit: starts=%0d busy=%b want %0d 1", start_cnt - base, busy, 1);
    end
    host_write(1'b0, 32'h4, "bp_clear");
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_clear_busy: busy=%b want 0", busy);
    end
  endtask

  task automatic test_auto();
    int base;
    base = start_cnt;
    host_write(1'b0, 32'h2, "auto_ctrl");
    write_block(128'hD0000001_D0000002_D0000003_D0000004, "auto_d");
    write_block(128'hE0000001_E0000002_E0000003_E0000004, "auto_e");
    wait_start(base + 1, "auto_first");
    n_checks++;
    if (last_din !== 128'hD0000001_D0000002_D0000003_D0000004) begin
      n_fail++;
      $display("FAIL auto_din1: got %h want d0000001d0000002d0000003d0000004", last_din);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (start_cnt !== base + 1) begin
      n_fail++;
      $display("FAIL auto_hold_in_wait: starts=%0d want 1", start_cnt - base);
    end
    core_reply(128'h11112222_33334444_55556666_77778888);
    drain_block(128'h11112222_33334444_55556666_77778888, -1, "auto_out1");
    n_checks++;
    if (start_cnt !== base + 1 || core_start !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_after_last: starts=%0d start=%b want 1 0", start_cnt - base, core_start);
    end
    wait_start(base + 2, "auto_second");
    n_checks++;
    if (last_din !== 128'hE0000001_E0000002_E0000003_E0000004) begin
      n_fail++;
      $display("FAIL auto_din2: got %h want e0000001e0000002e0000003e0000004", last_din);
    end
    core_reply(128'h9999aaaa_bbbbcccc_ddddeeee_ffff0000);
    drain_block(128'h9999aaaa_bbbbcccc_ddddeeee_ffff0000, 3, "auto_out2");
    host_write(1'b0, 32'h0, "auto_off");
  endtask

  task automatic test_clear_err();
    int base;
    base = start_cnt;
    host_write(1'b1, 32'h77000001, "clr_partial");
    host_write(1'b1, 32'h77000002, "clr_partial");
    host_write(1'b1, 32'h77000003, "clr_partial");
    host_write(1'b0, 32'h5, "clr_ctrl");
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (start_cnt !== base || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_no_dispatch: starts=%0d busy=%b want 0 0", start_cnt - base, busy);
    end
    write_block(128'h0F000001_0F000002_0F000003_0F000004, "clr_f");
    host_write(1'b0, 32'h1, "clr_start");
    wait_start(base + 1, "clr_dispatch");
    n_checks++;
    if (last_din !== 128'h0F000001_0F000002_0F000003_0F000004) begin
      n_fail++;
      $display("FAIL clr_packer_empty: got %h want 0f0000010f0000020f0000030f000004", last_din);
    end
    core_reply(128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3);
    drain_block(128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3, -1, "clr_out");
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_before: err=%b want 0", err);
    end
    core_reply(128'h0);
    n_checks++;
    if (err !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_set: err=%b m_valid=%b want 1 0", err, m_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b want 1", err);
    end
    host_write(1'b0, 32'h4, "err_clear");
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b want 0", err);
    end
  endtask

  task automatic test_reset_midop();
    int base;
    base = start_cnt;
    write_block(128'h42000001_42000002_42000003_42000004, "rst_blk");
    host_write(1'b0, 32'h1, "rst_start");
    wait_start(base + 1, "rst_dispatch");
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_before: busy=%b want 1", busy);
    end
    s_addr = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (core_start !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'h0 ||
        busy !== 1'b0 || err !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: start=%b mv=%b ml=%b md=%h busy=%b err=%b sr=%b want 0 0 0 0 0 0 1",
               core_start, m_valid, m_last, m_data, busy, err, s_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    core_reply(128'hdeadbeef_00000000_00000000_00000000);
    n_checks++;
    if (err !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_late_done: err=%b m_valid=%b want 1 0", err, m_valid);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    s_valid   = 1'b0;
    s_addr    = 1'b0;
    s_data    = '0;
    core_done = 1'b0;
    core_dout = '0;
    m_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_manual_output();
    test_backpressure();
    test_auto();
    test_clear_err();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
